tri_512x16_1r1w_ctl: RTL and testbench



---
 rtl/tri_512x16_1r1w_ctl_pkg.sv | 19 +
 rtl/tri_512x16_1r1w_ctl_init_seq.sv | 99 +++++++++
 rtl/tri_512x16_1r1w_ctl.sv | 121 ++++++++++++
 tb/tb_tri_512x16_1r1w_ctl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/tri_512x16_1r1w_ctl_pkg.sv
// Shared types and defaults for the 512x16 1r1w array front-end controller.
package tri_512x16_1r1w_ctl_pkg;

  localparam int ADR_W_DEF = 9;
  localparam int DATA_W_DEF = 16;
  localparam logic [15:0] INIT_VAL_DEF = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SWEEP = 2'b01,
    ST_DONE  = 2'b10
  } seq_state_e;

  // Last address visited by the zero-fill sweep.
  function automatic int sweep_last(input int adr_w);
    return (1 << adr_w) - 1;
  endfunction

endpackage

// File: rtl/tri_512x16_1r1w_ctl_init_seq.sv
// Init sweep sequencer: FSM, sweep counter, busy, and the array-port mux
// between the sweep and gated functional traffic.
module tri_ary_init_seq
  import tri_512x16_1r1w_ctl_pkg::*;
#(
  parameter int ADR_W = ADR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter bit INIT_ON_RESET = 1'b1,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_req,
  input  logic              fn_wr_act,
  input  logic [DATA_W-1:0] fn_bw,
  input  logic [ADR_W-1:0]  fn_wr_adr,
  input  logic [DATA_W-1:0] fn_di,
  input  logic              fn_rd_act,
  input  logic [ADR_W-1:0]  fn_rd_adr,
  output logic              busy,
  output seq_state_e        state,
  output logic              ary_wr_act,
  output logic [DATA_W-1:0] ary_bw,
  output logic [ADR_W-1:0]  ary_wr_adr,
  output logic [DATA_W-1:0] ary_di,
  output logic              ary_rd_act,
  output logic [ADR_W-1:0]  ary_rd_adr
);

  localparam logic [ADR_W-1:0] CNT_LAST = ADR_W'(sweep_last(ADR_W));

  seq_state_e       state_q, state_d;
  logic [ADR_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             start_pend_q, start_pend_d;

  // start_pend carries the automatic post-reset start into the first edge.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    start_pend_d = start_pend_q;
    case (state_q)
      ST_IDLE: begin
        if (!busy_q && (init_req || start_pend_q)) begin
          state_d      = ST_SWEEP;
          start_pend_d = 1'b0;
        end
      end
      ST_SWEEP: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Held one extra cycle past DONE so traffic resumes 514 cycles after start.
    busy_d = (state_d != ST_IDLE) || (state_q == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      start_pend_q <= INIT_ON_RESET;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
      start_pend_q <= start_pend_d;
    end
  end

  always_comb begin
    if (state_q == ST_SWEEP) begin
      ary_wr_act = 1'b1;
      ary_bw     = '1;
      ary_wr_adr = cnt_q;
      ary_di     = INIT_VAL;
      ary_rd_act = 1'b0;
      ary_rd_adr = '0;
    end else begin
      ary_wr_act = fn_wr_act;
      ary_bw     = fn_bw;
      ary_wr_adr = fn_wr_adr;
      ary_di     = fn_di;
      ary_rd_act = fn_rd_act;
      ary_rd_adr = fn_rd_adr;
    end
  end

  assign busy  = busy_q;
  assign state = state_q;

endmodule

// File: rtl/tri_512x16_1r1w_ctl.sv
// Front-end controller for the 512x16 1r1w array: request gating, drop
// tracking, same-cycle read/write bypass and the registered read-data stage.
module tri_512x16_1r1w_ctl
  import tri_512x16_1r1w_ctl_pkg::*;
#(
  parameter int ADR_W = ADR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter bit INIT_ON_RESET = 1'b1,
  parameter logic [DATA_W-1:0] INIT_VAL = DATA_W'(INIT_VAL_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_val,
  input  logic [ADR_W-1:0]  wr_adr,
  input  logic [DATA_W-1:0] wr_bw,
  input  logic [DATA_W-1:0] wr_di,
  input  logic              rd_val,
  input  logic [ADR_W-1:0]  rd_adr,
  input  logic              init_req,
  output logic              busy,
  output logic              err_drop,
  output logic              rd_data_val,
  output logic [DATA_W-1:0] rd_data,
  output logic              ary_wr_act,
  output logic [DATA_W-1:0] ary_bw,
  output logic [ADR_W-1:0]  ary_wr_adr,
  output logic [DATA_W-1:0] ary_di,
  output logic              ary_rd_act,
  output logic [ADR_W-1:0]  ary_rd_adr,
  input  logic [DATA_W-1:0] ary_do
);

  logic              busy_int;
  seq_state_e        seq_state;
  logic              acc_ok;
  logic              fn_wr_act, fn_rd_act;
  logic [DATA_W-1:0] fn_bw, fn_di;
  logic [ADR_W-1:0]  fn_wr_adr, fn_rd_adr;

  // Functional traffic reaches the array only in an idle, non-busy cycle.
  assign acc_ok    = (seq_state == ST_IDLE) && !busy_int && !rst;
  assign fn_wr_act = acc_ok && wr_val && (wr_bw != '0);
  assign fn_rd_act = acc_ok && rd_val;
  assign fn_bw     = acc_ok ? wr_bw  : '0;
  assign fn_di     = acc_ok ? wr_di  : '0;
  assign fn_wr_adr = acc_ok ? wr_adr : '0;
  assign fn_rd_adr = acc_ok ? rd_adr : '0;

  tri_ary_init_seq #(
    .ADR_W        (ADR_W),
    .DATA_W       (DATA_W),
    .INIT_ON_RESET(INIT_ON_RESET),
    .INIT_VAL     (INIT_VAL)
  ) u_init_seq (
    .clk       (clk),
    .rst       (rst),
    .init_req  (init_req),
    .fn_wr_act (fn_wr_act),
    .fn_bw     (fn_bw),
    .fn_wr_adr (fn_wr_adr),
    .fn_di     (fn_di),
    .fn_rd_act (fn_rd_act),
    .fn_rd_adr (fn_rd_adr),
    .busy      (busy_int),
    .state     (seq_state),
    .ary_wr_act(ary_wr_act),
    .ary_bw    (ary_bw),
    .ary_wr_adr(ary_wr_adr),
    .ary_di    (ary_di),
    .ary_rd_act(ary_rd_act),
    .ary_rd_adr(ary_rd_adr)
  );

  logic              err_drop_q, err_drop_d;
  logic              rd_pend_q, rd_pend_d;
  logic              col_q, col_d;
  logic [DATA_W-1:0] col_bw_q, col_bw_d;
  logic [DATA_W-1:0] col_di_q, col_di_d;
  logic              rd_data_val_q, rd_data_val_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [DATA_W-1:0] merged;

  // The array returns pre-write data for a same-cycle collision, so the
  // write bits are overlaid onto ary_do one cycle later.
  always_comb begin
    err_drop_d    = err_drop_q || (busy_int && (wr_val || rd_val));
    rd_pend_d     = fn_rd_act;
    col_d         = fn_rd_act && fn_wr_act && (rd_adr == wr_adr);
    col_bw_d      = col_d ? wr_bw : '0;
    col_di_d      = col_d ? wr_di : '0;
    merged        = col_q ? ((ary_do & ~col_bw_q) | (col_di_q & col_bw_q)) : ary_do;
    rd_data_val_d = rd_pend_q;
    rd_data_d     = rd_pend_q ? merged : rd_data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_drop_q    <= 1'b0;
      rd_pend_q     <= 1'b0;
      col_q         <= 1'b0;
      col_bw_q      <= '0;
      col_di_q      <= '0;
      rd_data_val_q <= 1'b0;
      rd_data_q     <= '0;
    end else begin
      err_drop_q    <= err_drop_d;
      rd_pend_q     <= rd_pend_d;
      col_q         <= col_d;
      col_bw_q      <= col_bw_d;
      col_di_q      <= col_di_d;
      rd_data_val_q <= rd_data_val_d;
      rd_data_q     <= rd_data_d;
    end
  end

  assign busy        = busy_int;
  assign err_drop    = err_drop_q;
  assign rd_data_val = rd_data_val_q;
  assign rd_data     = rd_data_q;

endmodule

// File: tb/tb_tri_512x16_1r1w_ctl.sv
// Directed bench for tri_512x16_1r1w_ctl with a behavioural 512x16 array and
// a read-data scoreboard.
module tb_tri_512x16_1r1w_ctl;

  localparam logic [15:0] INIT = 16'h0000;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        wr_val = 1'b0;
  logic [8:0]  wr_adr = '0;
  logic [15:0] wr_bw = '0;
  logic [15:0] wr_di = '0;
  logic        rd_val = 1'b0;
  logic [8:0]  rd_adr = '0;
  logic        init_req = 1'b0;
  logic        busy, err_drop, rd_data_val;
  logic [15:0] rd_data;
  logic        ary_wr_act, ary_rd_act;
  logic [15:0] ary_bw, ary_di;
  logic [8:0]  ary_wr_adr, ary_rd_adr;
  logic [15:0] ary_do = '0;

  tri_512x16_1r1w_ctl dut (
    .clk(clk), .rst(rst),
    .wr_val(wr_val), .wr_adr(wr_adr), .wr_bw(wr_bw), .wr_di(wr_di),
    .rd_val(rd_val), .rd_adr(rd_adr), .init_req(init_req),
    .busy(busy), .err_drop(err_drop), .rd_data_val(rd_data_val), .rd_data(rd_data),
    .ary_wr_act(ary_wr_act), .ary_bw(ary_bw), .ary_wr_adr(ary_wr_adr), .ary_di(ary_di),
    .ary_rd_act(ary_rd_act), .ary_rd_adr(ary_rd_adr), .ary_do(ary_do)
  );

  // Behavioural array: read returns pre-write contents, data one cycle later.
  logic [15:0] ary_mem [0:511];
  always @(posedge clk) begin
    if (ary_rd_act) ary_do <= ary_mem[ary_rd_adr];
    if (ary_wr_act) ary_mem[ary_wr_adr] <= (ary_mem[ary_wr_adr] & ~ary_bw) | (ary_di & ary_bw);
  end

  // Scoreboard
  logic [15:0] ref_mem [0:511];
  logic [15:0] exp_q[$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [15:0] e;
    if (!rst && rd_data_val) begin
      if (exp_q.size() == 0) begin
        chk("rd_unexpected_val", {63'd0, rd_data_val}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("rd_data", {48'd0, rd_data}, {48'd0, e});
      end
    end
  end

  // Driver tasks
  task automatic fill_ref();
    for (int a = 0; a < 512; a++) ref_mem[a] = INIT;
  endtask

  task automatic drive(input logic wv, input logic [8:0] wa, input logic [15:0] bw,
                       input logic [15:0] di, input logic rv, input logic [8:0] ra,
                       input logic ir);
    logic [15:0] e;
    @(negedge clk);
    wr_val = wv; wr_adr = wa; wr_bw = bw; wr_di = di;
    rd_val = rv; rd_adr = ra; init_req = ir;
    if (rv) begin
      e = ref_mem[ra];
      if (wv && (wa == ra)) e = (e & ~bw) | (di & bw);
      exp_q.push_back(e);
    end
    if (wv) ref_mem[wa] = (ref_mem[wa] & ~bw) | (di & bw);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_status"}, {45'd0, busy, err_drop, rd_data_val, rd_data}, 64'd0);
    chk({tag, "_ary"}, {12'd0, ary_wr_act, ary_bw, ary_wr_adr, ary_di, ary_rd_act, ary_rd_adr}, 64'd0);
  endtask

  // Follows one sweep starting at the next negedge; optionally drops a read
  // at drop_at or asserts rst at rst_at.
  task automatic watch_sweep(input int drop_at, input int rst_at, input logic err_in);
    logic err_e;
    logic [8:0] a;
    err_e = err_in;
    for (int i = 0; i < 512; i++) begin
      @(negedge clk);
      wr_val = 0; wr_adr = '0; wr_bw = '0; wr_di = '0;
      rd_val = 0; rd_adr = '0; init_req = 0;
      if (i == drop_at) begin rd_val = 1'b1; rd_adr = 9'h055; end
      if (i == 200) init_req = 1'b1;
      #1;
      a = i[8:0];
      chk($sformatf("sweep[%0d]", i),
          {18'd0, ary_wr_act, ary_bw, ary_wr_adr, ary_di, busy, ary_rd_act, rd_data_val, err_drop},
          {18'd0, 1'b1, 16'hFFFF, a, INIT, 1'b1, 1'b0, 1'b0, err_e});
      if (i == drop_at) err_e = 1'b1;
      if (i == rst_at) begin
        rst = 1'b1;
        #1;
        chk_reset("rst_mid_sweep");
        return;
      end
    end
    @(negedge clk);
    init_req = 1'b1;
    #1;
    chk("sweep_done", {61'd0, busy, ary_wr_act, err_drop}, {61'd0, 1'b1, 1'b0, err_e});
    @(negedge clk);
    init_req = 1'b0;
    #1;
    chk("sweep_busy_tail", {62'd0, busy, ary_wr_act}, {62'd0, 1'b1, 1'b0});
  endtask

  initial begin
    for (int a = 0; a < 512; a++) begin
      ary_mem[a] = 16'($urandom_range(0, 16'hFFFF));
      ref_mem[a] = ary_mem[a];
    end

    // Reset values, then the automatic sweep with a dropped read at cycle 100
    repeat (3) @(negedge clk);
    #1;
    chk_reset("reset");
    rst = 1'b0;
    fill_ref();
    watch_sweep(100, -1, 1'b0);

    // First accepted request, 514 cycles after sweep start
    drive(1'b0, '0, '0, '0, 1'b1, 9'h1A5, 1'b0);
    chk("first_read_issue", {53'd0, busy, ary_rd_act, ary_rd_adr}, {53'd0, 1'b0, 1'b1, 9'h1A5});
    idle();
    idle();
    chk("err_sticky", {63'd0, err_drop}, 64'd1);

    // Write then read next cycle; rd_data_val one cycle, rd_data holds
    drive(1'b1, 9'h0C3, 16'hFFFF, 16'hBEEF, 1'b0, '0, 1'b0);
    chk("wr_pass", {22'd0, ary_wr_act, ary_wr_adr, ary_bw, ary_di},
        {22'd0, 1'b1, 9'h0C3, 16'hFFFF, 16'hBEEF});
    drive(1'b0, '0, '0, '0, 1'b1, 9'h0C3, 1'b0);
    idle();
    chk("rd_val_n1", {63'd0, rd_data_val}, 64'd0);
    idle();
    chk("rd_val_n2", {47'd0, rd_data_val, rd_data}, {47'd0, 1'b1, 16'hBEEF});
    idle();
    chk("rd_hold", {47'd0, rd_data_val, rd_data}, {47'd0, 1'b0, 16'hBEEF});

    // Same-cycle collision with partial byte write
    drive(1'b1, 9'h010, 16'hFFFF, 16'hABCD, 1'b0, '0, 1'b0);
    idle();
    drive(1'b1, 9'h010, 16'hFF00, 16'h1234, 1'b1, 9'h010, 1'b0);
    idle();
    idle();
    chk("bypass", {48'd0, rd_data}, {48'd0, 16'h12CD});

    // Zero byte-enable write is a no-op
    drive(1'b1, 9'h020, 16'h0000, 16'hFFFF, 1'b0, '0, 1'b0);
    chk("bw0_noop", {63'd0, ary_wr_act}, 64'd0);
    drive(1'b0, '0, '0, '0, 1'b1, 9'h020, 1'b0);

    // Random back-to-back traffic over a small address window
    for (int k = 0; k < 80; k++) begin
      logic [15:0] bw;
      case ($urandom_range(0, 3))
        0: bw = 16'h0000;
        1: bw = 16'hFFFF;
        default: bw = 16'($urandom_range(0, 16'hFFFF));
      endcase
      drive(1'($urandom_range(0, 1)), 9'h100 + 9'($urandom_range(0, 7)), bw,
            16'($urandom_range(0, 16'hFFFF)), 1'($urandom_range(0, 1)),
            9'h100 + 9'($urandom_range(0, 7)), 1'b0);
    end
    repeat (3) idle();

    // init_req together with a write: write issued, then swept over
    drive(1'b1, 9'h1FF, 16'hFFFF, 16'h5555, 1'b0, '0, 1'b1);
    chk("init_wr_same_cycle", {38'd0, ary_wr_act, ary_wr_adr, ary_di, busy},
        {38'd0, 1'b1, 9'h1FF, 16'h5555, 1'b0});
    fill_ref();
    watch_sweep(-1, -1, 1'b1);
    drive(1'b0, '0, '0, '0, 1'b1, 9'h1FF, 1'b0);
    idle();
    drive(1'b1, 9'h0AA, 16'hFFFF, 16'h7E57, 1'b0, '0, 1'b0);
    drive(1'b0, '0, '0, '0, 1'b1, 9'h0AA, 1'b0);
    repeat (3) idle();
    chk("pre_rst_data", {48'd0, rd_data}, {48'd0, 16'h7E57});

    // Reset at sweep address 300, sweep restarts from 0
    drive(1'b0, '0, '0, '0, 1'b0, '0, 1'b1);
    fill_ref();
    watch_sweep(-1, 300, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    watch_sweep(-1, -1, 1'b0);
    drive(1'b0, '0, '0, '0, 1'b1, 9'h12C, 1'b0);
    repeat (3) idle();
    chk("err_after_rst", {63'd0, err_drop}, 64'd0);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
